// File: rtl/code_burst_pkg.sv
// Shared types and default widths for the code burst sequencer slice.
package code_burst_pkg;

    localparam int unsigned DEF_CODE_W = 2;
    localparam int unsigned DEF_NUM_W  = 3;
    localparam int unsigned DEF_CNT_W  = 8;

    // Code the upstream decode stage presents right after its own reset
    localparam logic [1:0] UPSTREAM_RST_CODE = 2'h1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage

// File: rtl/code_change_det.sv
// Mode-code change detector: remembers last cycle's code, flags any change,
// and keeps a saturating count of detected changes.
module code_change_det
    import code_burst_pkg::*;
#(
    parameter int unsigned CODE_W = DEF_CODE_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] i_code,
    output logic              o_chg_c,
    output logic [CNT_W-1:0]  o_chg_count
);

    logic [CODE_W-1:0] r_code_prev;
    logic [CNT_W-1:0]  r_chg_count;

    assign o_chg_c     = (i_code != r_code_prev);
    assign o_chg_count = r_chg_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code_prev <= '0;
            r_chg_count <= '0;
        end else begin
            r_code_prev <= i_code;
            if (o_chg_c && (r_chg_count != '1)) begin
                r_chg_count <= r_chg_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/code_burst_sequencer.sv
// Turns each mode-code change into a burst of valid/ready beats, parking one
// change while busy and flagging any further changes as dropped.
module code_burst_sequencer
    import code_burst_pkg::*;
#(
    parameter int unsigned CODE_W = DEF_CODE_W,
    parameter int unsigned NUM_W  = DEF_NUM_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic [NUM_W-1:0]  num_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [NUM_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  chg_count,
    output logic              drop_sticky,
    input  logic              drop_clr
);

    state_t            r_state;
    logic [CODE_W-1:0] r_cur_code;
    logic [CODE_W-1:0] r_pend_code;
    logic              r_pend_vld;
    logic [NUM_W-1:0]  r_len;
    logic              r_out_valid;
    logic [CODE_W-1:0] r_out_code;
    logic [NUM_W-1:0]  r_out_idx;
    logic              r_out_last;
    logic              r_busy;
    logic              r_drop;

    logic              w_chg;
    logic              w_done;
    logic              w_drop;
    logic [NUM_W-1:0]  w_idx_nxt;
    logic [NUM_W-1:0]  w_last_idx;

    code_change_det #(
        .CODE_W (CODE_W),
        .CNT_W  (CNT_W)
    ) u_change_det (
        .clk         (clk),
        .rst         (rst),
        .i_code      (code_in),
        .o_chg_c     (w_chg),
        .o_chg_count (chg_count)
    );

    // A burst ends either on its final handshake or immediately when armed with length 0
    assign w_done = ((r_state == ARM) && (num_in == '0)) ||
                    ((r_state == BURST) && r_out_valid && out_ready && r_out_last);
    assign w_drop = w_chg && (r_state != IDLE) && !w_done && r_pend_vld;

    assign w_idx_nxt  = r_out_idx + NUM_W'(1);
    assign w_last_idx = r_len - NUM_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cur_code  <= '0;
            r_pend_code <= '0;
            r_pend_vld  <= 1'b0;
            r_len       <= '0;
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            if (w_drop) begin
                r_drop <= 1'b1;
            end else if (drop_clr) begin
                r_drop <= 1'b0;
            end

            if (w_chg && (r_state != IDLE) && !w_done && !r_pend_vld) begin
                r_pend_vld  <= 1'b1;
                r_pend_code <= code_in;
            end

            case (r_state)
                IDLE: begin
                    if (w_chg) begin
                        r_cur_code <= code_in;
                        r_state    <= ARM;
                        r_busy     <= 1'b1;
                    end
                end
                // num_in lags code_in by a cycle, so the length is only sampled here
                ARM: begin
                    if (num_in != '0) begin
                        r_len       <= num_in;
                        r_state     <= BURST;
                        r_out_valid <= 1'b1;
                        r_out_code  <= r_cur_code;
                        r_out_idx   <= '0;
                        r_out_last  <= (num_in == NUM_W'(1));
                    end
                end
                BURST: begin
                    if (r_out_valid && out_ready && !r_out_last) begin
                        r_out_idx  <= w_idx_nxt;
                        r_out_last <= (w_idx_nxt == w_last_idx);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Completion: parked change first, then a same-cycle change, else go idle
            if (w_done) begin
                r_out_valid <= 1'b0;
                r_out_code  <= '0;
                r_out_idx   <= '0;
                r_out_last  <= 1'b0;
                if (r_pend_vld) begin
                    r_cur_code  <= r_pend_code;
                    r_state     <= ARM;
                    r_pend_vld  <= w_chg;
                    r_pend_code <= code_in;
                end else if (w_chg) begin
                    r_cur_code <= code_in;
                    r_state    <= ARM;
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_code    = r_out_code;
    assign out_idx     = r_out_idx;
    assign out_last    = r_out_last;
    assign busy        = r_busy;
    assign drop_sticky = r_drop;

endmodule

// File: tb/tb_code_burst_sequencer.sv
// Scoreboard bench for code_burst_sequencer: a transaction-level model queues
// expected beats, and an independent monitor checks every presented beat.
module tb_code_burst_sequencer;
    import code_burst_pkg::*;

    localparam int unsigned CW = DEF_CODE_W;
    localparam int unsigned NW = DEF_NUM_W;
    localparam int unsigned KW = DEF_CNT_W;
    localparam int CNT_MAX = (1 << KW) - 1;

    typedef struct packed {
        logic [CW-1:0] code;
        logic [NW-1:0] idx;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] code_in;
    logic [NW-1:0] num_in;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_code;
    logic [NW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic [KW-1:0] chg_count;
    logic          drop_sticky;
    logic          drop_clr;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    // Expected beats, pushed by the model when a burst is armed
    beat_t sb[$];

    // Reference model: 0 = waiting, 1 = arming, 2 = streaming
    logic [CW-1:0] m_prev;
    logic [CW-1:0] m_cur;
    logic [CW-1:0] m_pend[$];
    int            m_cnt;
    int            m_mode;
    int            m_left;
    logic          m_drop;

    code_burst_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .num_in      (num_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .chg_count   (chg_count),
        .drop_sticky (drop_sticky),
        .drop_clr    (drop_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_cur  = '0;
        m_cnt  = 0;
        m_mode = 0;
        m_left = 0;
        m_drop = 1'b0;
        m_pend.delete();
        sb.delete();
    endtask

    // Applies one cycle's inputs to the model
    task automatic model_step(input logic [CW-1:0] c, input logic [NW-1:0] n,
                              input logic rdy, input logic dc, input logic r);
        bit    chg;
        bit    was_busy;
        bit    done;
        bit    dropped;
        beat_t b;
        if (r) begin
            model_reset();
            return;
        end
        chg      = (c != m_prev);
        m_prev   = c;
        was_busy = (m_mode != 0);
        done     = 1'b0;
        dropped  = 1'b0;
        if (chg && m_cnt < CNT_MAX) m_cnt++;
        if (m_mode == 0) begin
            if (chg) begin
                m_cur  = c;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (n == '0) begin
                done = 1'b1;
            end else begin
                for (int i = 0; i < int'(n); i++) begin
                    b.code = m_cur;
                    b.idx  = NW'(i);
                    b.last = (i == int'(n) - 1);
                    sb.push_back(b);
                end
                m_left = int'(n);
                m_mode = 2;
            end
        end else if (rdy) begin
            m_left--;
            if (m_left == 0) done = 1'b1;
        end
        if (chg && was_busy && !done) begin
            if (m_pend.size() == 0) m_pend.push_back(c);
            else dropped = 1'b1;
        end
        if (done) begin
            if (m_pend.size() != 0) begin
                m_cur  = m_pend.pop_front();
                m_mode = 1;
                if (chg) m_pend.push_back(c);
            end else if (chg) begin
                m_cur  = c;
                m_mode = 1;
            end else begin
                m_mode = 0;
            end
        end
        if (dropped) m_drop = 1'b1;
        else if (dc) m_drop = 1'b0;
    endtask

    // Drive one cycle, check status outputs against the model, then advance it
    task automatic run_cycle(input logic [CW-1:0] c, input logic [NW-1:0] n,
                             input logic rdy, input logic dc, input logic r);
        @(posedge clk);
        #1;
        code_in   = c;
        num_in    = n;
        out_ready = rdy;
        drop_clr  = dc;
        rst       = r;
        @(negedge clk);
        #1;
        chk("out_valid",   32'(out_valid),   32'(m_mode == 2));
        chk("busy",        32'(busy),        32'(m_mode != 0));
        chk("chg_count",   32'(chg_count),   32'(m_cnt));
        chk("drop_sticky", 32'(drop_sticky), 32'(m_drop));
        model_step(c, n, rdy, dc, r);
    endtask

    // Monitor: every presented beat must match the head of the scoreboard
    always @(negedge clk) begin : monitor
        beat_t exp_b;
        if (mon_en && out_valid === 1'b1) begin
            chk("beat_expected", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
                exp_b = sb[0];
                chk("out_code", 32'(out_code), 32'(exp_b.code));
                chk("out_idx",  32'(out_idx),  32'(exp_b.idx));
                chk("out_last", 32'(out_last), 32'(exp_b.last));
                if (out_ready === 1'b1) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [CW-1:0] rc;
        rst       = 1'b1;
        code_in   = '0;
        num_in    = '0;
        out_ready = 1'b0;
        drop_clr  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // Reset state, then release with the upstream post-reset code
        run_cycle(2'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        run_cycle(2'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        run_cycle(UPSTREAM_RST_CODE, 3'd0, 1'b1, 1'b0, 1'b0);
        repeat (6) run_cycle(UPSTREAM_RST_CODE, 3'd3, 1'b1, 1'b0, 1'b0);

        // Length-4 burst under a 1,0,0,1 ready pattern
        run_cycle(2'd2, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            run_cycle(2'd2, 3'd4, ((i % 4) == 0) || ((i % 4) == 3), 1'b0, 1'b0);
        end

        // Zero-length bursts
        run_cycle(2'd1, 3'd0, 1'b1, 1'b0, 1'b0);
        run_cycle(2'd1, 3'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) run_cycle(2'd3, 3'd0, 1'b1, 1'b0, 1'b0);

        // Stalled burst collecting one pending change and two drops
        run_cycle(2'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        run_cycle(2'd1, 3'd5, 1'b0, 1'b0, 1'b0);
        run_cycle(2'd3, 3'd5, 1'b0, 1'b0, 1'b0);
        run_cycle(2'd1, 3'd5, 1'b0, 1'b0, 1'b0);
        run_cycle(2'd3, 3'd5, 1'b0, 1'b0, 1'b0);
        repeat (2) run_cycle(2'd3, 3'd2, 1'b0, 1'b0, 1'b0);
        repeat (12) run_cycle(2'd3, 3'd2, 1'b1, 1'b0, 1'b0);
        run_cycle(2'd3, 3'd2, 1'b1, 1'b1, 1'b0);
        run_cycle(2'd3, 3'd2, 1'b1, 1'b0, 1'b0);

        // Change landing on the final handshake
        run_cycle(2'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        run_cycle(2'd0, 3'd2, 1'b1, 1'b0, 1'b0);
        run_cycle(2'd0, 3'd2, 1'b1, 1'b0, 1'b0);
        run_cycle(2'd2, 3'd2, 1'b1, 1'b0, 1'b0);
        repeat (4) run_cycle(2'd2, 3'd1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a burst
        run_cycle(2'd1, 3'd0, 1'b1, 1'b0, 1'b0);
        run_cycle(2'd1, 3'd4, 1'b1, 1'b0, 1'b0);
        run_cycle(2'd1, 3'd4, 1'b1, 1'b0, 1'b0);
        run_cycle(2'd1, 3'd4, 1'b0, 1'b0, 1'b1);
        run_cycle(UPSTREAM_RST_CODE, 3'd4, 1'b1, 1'b0, 1'b0);
        repeat (5) run_cycle(UPSTREAM_RST_CODE, 3'd2, 1'b1, 1'b0, 1'b0);

        // Toggle every cycle to saturate the change counter
        for (int i = 0; i < 300; i++) begin
            run_cycle(((i % 2) != 0) ? 2'd2 : 2'd1, 3'd1, 1'b1, 1'b0, 1'b0);
        end
        repeat (4) run_cycle(2'd2, 3'd1, 1'b1, 1'b1, 1'b0);

        // Randomized traffic
        rc = 2'd2;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) rc = CW'($urandom);
            run_cycle(rc, NW'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
                      ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
        end

        repeat (30) run_cycle(rc, 3'd3, 1'b1, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/code_burst_sequencer.md
Name: code_burst_sequencer

Overview:
- Downstream consumer of the state-decode stage's outputs: the 2-bit mode code and the 3-bit registered number.
- Detects every change of the mode code, then emits a burst of beats on a valid/ready stream. The burst length is the number value.
- Queues one pending change while busy, drops any further changes, and keeps a saturating change counter for debug.

Parameters:
CODE_W, 2, width of code_in / out_code
NUM_W, 3, width of num_in / out_idx
CNT_W, 8, width of chg_count

Ports:
clk  in  1  clock
rst  in  1  reset
code_in  in  CODE_W  mode code from upstream (combinational from upstream state)
num_in  in  NUM_W  burst length from upstream (registered; lags code_in by 1 cycle)
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
out_code  out  CODE_W  code of current burst
out_idx  out  NUM_W  beat index within burst, 0-based
out_last  out  1  final beat of burst
busy  out  1  state != IDLE
chg_count  out  CNT_W  saturating count of detected code changes
drop_sticky  out  1  a change was lost (pending slot already full)
drop_clr  in  1  clears drop_sticky

Behaviour:
- Reset: clk, rst, synchronous, active-high. All registers clear: state=IDLE, code_prev=0, pending empty, chg_count=0, drop_sticky=0. All outputs are 0 during and after reset.
- Change detect:
  - chg = (code_in != code_prev); code_prev <= code_in every cycle.
  - Upstream's post-reset code is 2'h1, so a change event fires in the first cycle after rst deasserts.
- chg_count increments on each chg and saturates at 2^CNT_W-1.
- State machine:
  - IDLE: on chg, latch cur_code <= code_in and go to ARM.
  - ARM (one cycle): latch len <= num_in. This cycle is needed because num_in is one cycle behind code_in.
    - If num_in == 0: no beats; go to IDLE, or to ARM if pending is valid.
    - Otherwise go to BURST with idx=0.
  - BURST:
    - out_valid=1, out_code=cur_code, out_idx=idx, out_last=(idx==len-1).
    - On out_valid&&out_ready: if out_last, burst completes; else idx++.
    - out_code, out_idx and out_last are held stable while out_valid && !out_ready.
- Latency: chg in cycle N gives the first out_valid in cycle N+2.
- Pending slot (depth 1, code only):
  - chg while state != IDLE: if pending is empty, store code_in; else set drop_sticky and keep the old pending.
- Burst completion:
  - Pending valid: go to ARM with cur_code <= pending code and clear pending. A chg in the same cycle refills pending.
  - Pending empty and chg in the same cycle: go to ARM with cur_code <= code_in.
  - Otherwise: go to IDLE.
- drop_clr: clears drop_sticky; a same-cycle drop event wins (sticky stays 1).
- Mid-burst rst: aborts immediately. out_valid=0 next cycle, and the pending change is discarded.
- out_valid is 0 in IDLE and ARM.

Decomposition:
- Package code_burst_pkg holds:
  - state enum {IDLE, ARM, BURST} (2 bits);
  - CODE_W/NUM_W/CNT_W defaults;
  - localparam UPSTREAM_RST_CODE = 2'h1 for benches.
- One natural sub-module: code_change_det. It holds code_prev, the chg output, and the saturating chg_count.
- The FSM, pending slot and output stage stay in the top module.

Test Plan:
- Reset release with code_in=1 (was 0), num_in=3 one cycle later, out_ready=1 → chg_count=1; out_valid from cycle N+2 for 3 cycles; out_idx 0,1,2; out_last only on idx 2; busy drops after the last beat.
- Burst len 4 with out_ready toggling 1,0,0,1,… → beats held stable while stalled; exactly 4 handshakes; out_idx never skips.
- num_in=0 after a change 1→3 → ARM then IDLE; zero out_valid cycles; chg_count incremented.
- Three code changes (3→1→3→1) during one burst with out_ready=0 → first change is pending, the rest set drop_sticky=1. After release: second burst uses code 3 and the current num_in; drop_clr clears sticky.
- Change arrives in the exact last-handshake cycle with pending empty → next cycle is ARM with the new code; no IDLE gap; no drop.
- rst asserted mid-burst (idx=1) → next cycle out_valid=0, busy=0, chg_count=0, pending empty; the post-reset change detect fires again.
